sync_fifo_hs: RTL

//  Single-clock FIFO with full/empty protection, registered read data with a valid strobe,

---
 rtl/sync_fifo_hs_if.sv | 32 +++
 rtl/sync_fifo_hs.sv | 96 +++++++++
 2 files changed

// File: rtl/sync_fifo_hs_if.sv
// Handshake and status bundle for sync_fifo_hs.
// The producer or consumer side uses the master modport, and the FIFO uses the slave modport.
interface sync_fifo_hs_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic                  clr;
   logic                  w_enable;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  r_enable;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic [ADDR_WIDTH:0]   count;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output clr, w_enable, w_data, r_enable,
      input  r_data, r_valid, count, full, empty, almost_full, almost_empty,
             overflow, underflow
   );

   modport slave (
      input  clr, w_enable, w_data, r_enable,
      output r_data, r_valid, count, full, empty, almost_full, almost_empty,
             overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_hs.sv
// Single-clock byte FIFO with registered read data, a valid strobe, programmable level flags,
// sticky overflow/underflow flags and a synchronous flush.
module sync_fifo_hs #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int AF_LEVEL   = 14,
   parameter int AE_LEVEL   = 2
) (
   input  logic           CLK,
   input  logic           RST_N,
   sync_fifo_hs_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] ram [DEPTH];
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH:0]   count_q;
   logic [DATA_WIDTH-1:0] r_data_q;
   logic                  r_valid_q;
   logic                  overflow_q;
   logic                  underflow_q;
   logic                  empty;
   logic                  full;
   logic                  rd_ok;
   logic                  wr_ok;

   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH_C);

   // Handshake: a read is accepted when r_enable is high and the FIFO is not empty.
   // A write is accepted when w_enable is high and the FIFO is not full, or when a read
   // is accepted in the same cycle. r_valid pulses for one cycle when r_data holds the word
   // from an accepted read. Nothing is accepted during reset or clr.
   assign rd_ok = bus.r_enable & ~empty;
   assign wr_ok = bus.w_enable & (~full | rd_ok);

   always_ff @(posedge CLK) begin
      if (RST_N && !bus.clr && wr_ok) begin
         ram[w_addr] <= bus.w_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         w_addr      <= '0;
         r_addr      <= '0;
         count_q     <= '0;
         r_data_q    <= '0;
         r_valid_q   <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.clr) begin
         // A flush empties the FIFO but leaves the last read word visible.
         w_addr      <= '0;
         r_addr      <= '0;
         count_q     <= '0;
         r_valid_q   <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         r_valid_q <= rd_ok;
         if (wr_ok) begin
            w_addr <= w_addr + ADDR_WIDTH'(1);
         end
         if (rd_ok) begin
            r_data_q <= ram[r_addr];
            r_addr   <= r_addr + ADDR_WIDTH'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (bus.w_enable && !wr_ok) begin
            overflow_q <= 1'b1;
         end
         if (bus.r_enable && !rd_ok) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign bus.r_data       = r_data_q;
   assign bus.r_valid      = r_valid_q;
   assign bus.count        = count_q;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= AF_C);
   assign bus.almost_empty = (count_q <= AE_C);
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule
